// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM ramp controller.
// The state encoding is visible on state_o, so its values are fixed here.
package pwm_pkg;

  localparam int CNT_WIDTH_DEF = 32;

  localparam logic [2:0] ST_IDLE_ENC       = 3'd0;
  localparam logic [2:0] ST_RAMP_ENC       = 3'd1;
  localparam logic [2:0] ST_RUN_ENC        = 3'd2;
  localparam logic [2:0] ST_STOP_RAMP_ENC  = 3'd3;
  localparam logic [2:0] ST_STOP_DRAIN_ENC = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE       = ST_IDLE_ENC,
    ST_RAMP       = ST_RAMP_ENC,
    ST_RUN        = ST_RUN_ENC,
    ST_STOP_RAMP  = ST_STOP_RAMP_ENC,
    ST_STOP_DRAIN = ST_STOP_DRAIN_ENC
  } pwm_ctrl_state_e;

endpackage

// File: rtl/pwm_duty_stepper.sv
// Combinational saturating step of the current duty toward a target.
// A zero step jumps straight to the target.
module pwm_duty_stepper #(
  parameter int CNT_WIDTH = 32
) (
  input  logic [CNT_WIDTH-1:0] cur,
  input  logic [CNT_WIDTH-1:0] tgt,
  input  logic [CNT_WIDTH-1:0] step,
  output logic [CNT_WIDTH-1:0] nxt_duty
);

  localparam int EW = CNT_WIDTH + 2;

  // Clamp a widened signed result back into the unsigned counter range.
  function automatic logic [CNT_WIDTH-1:0] sat_cnt(input logic signed [EW-1:0] v);
    if (v < 0) return '0;
    if (v > $signed({2'b00, {CNT_WIDTH{1'b1}}})) return '1;
    return v[CNT_WIDTH-1:0];
  endfunction

  logic signed [EW-1:0] cur_s;
  logic signed [EW-1:0] step_s;
  logic signed [EW-1:0] up_s;
  logic signed [EW-1:0] dn_s;
  logic [CNT_WIDTH-1:0] up_sat;
  logic [CNT_WIDTH-1:0] dn_sat;

  assign cur_s  = $signed({2'b00, cur});
  assign step_s = $signed({2'b00, step});
  assign up_s   = cur_s + step_s;
  assign dn_s   = cur_s - step_s;
  assign up_sat = sat_cnt(up_s);
  assign dn_sat = sat_cnt(dn_s);

  always_comb begin
    nxt_duty = cur;
    if (step == '0 || cur == tgt) begin
      nxt_duty = tgt;
    end else if (cur < tgt) begin
      nxt_duty = (up_sat > tgt) ? tgt : up_sat;
    end else begin
      nxt_duty = (dn_sat < tgt) ? tgt : dn_sat;
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Configuration/sequencing front-end for pwm_core_ip: shadowed config,
// period-boundary updates, soft start/stop ramps and core enable ownership.
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int CNT_WIDTH             = CNT_WIDTH_DEF,
  parameter int DEFAULT_PERIOD_CYCLES = 20,
  parameter int DEFAULT_DUTY_CYCLES   = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [CNT_WIDTH-1:0] cfg_period_i,
  input  logic [CNT_WIDTH-1:0] cfg_duty_i,
  input  logic [CNT_WIDTH-1:0] cfg_step_i,
  input  logic                 period_end_i,
  output logic                 pwm_enable_o,
  output logic [CNT_WIDTH-1:0] period_cycles_o,
  output logic [CNT_WIDTH-1:0] duty_cycles_o,
  output logic                 use_default_duty_o,
  output logic [2:0]           state_o,
  output logic                 at_target_o,
  output logic                 busy_o
);

  localparam logic [CNT_WIDTH-1:0] DFLT_PERIOD = CNT_WIDTH'(DEFAULT_PERIOD_CYCLES);
  localparam logic [CNT_WIDTH-1:0] DFLT_DUTY   = CNT_WIDTH'(DEFAULT_DUTY_CYCLES);
  localparam logic [CNT_WIDTH-1:0] MIN_PERIOD  = CNT_WIDTH'(2);
  localparam logic [CNT_WIDTH-1:0] DFLT_STEP   = CNT_WIDTH'(1);

  pwm_ctrl_state_e state_q, state_d;
  logic                 en_q, en_d;
  logic                 udd_q, udd_d;
  logic [CNT_WIDTH-1:0] duty_q, duty_d;
  logic [CNT_WIDTH-1:0] period_q, tgt_q, step_q;
  logic                 sh_full_q;
  logic [CNT_WIDTH-1:0] sh_period_q, sh_duty_q, sh_step_q;

  logic                 cfg_xfer, apply, stopping, resume, step_en;
  logic [CNT_WIDTH-1:0] cap_period, cap_duty;
  logic [CNT_WIDTH-1:0] period_nx, tgt_nx, step_nx, ramp_tgt, stepped, duty_nx;

  // Sanitise the offered config at capture so the shadow always holds legal values.
  assign cap_period = (cfg_period_i < MIN_PERIOD) ? DFLT_PERIOD : cfg_period_i;
  assign cap_duty   = (cfg_duty_i > cap_period) ? cap_period : cfg_duty_i;
  assign cfg_xfer   = cfg_valid_i && !sh_full_q;
  assign apply      = sh_full_q && (state_q == ST_IDLE || period_end_i);

  assign period_nx = apply ? sh_period_q : period_q;
  assign tgt_nx    = apply ? sh_duty_q   : tgt_q;
  assign step_nx   = apply ? sh_step_q   : step_q;

  // A start while stopping resumes toward the programmed target from the current duty.
  assign stopping = (state_q == ST_STOP_RAMP) || (state_q == ST_STOP_DRAIN);
  assign resume   = start_i && !stop_i && stopping;
  assign ramp_tgt = (state_q == ST_STOP_RAMP && !resume) ? '0 : tgt_nx;
  assign step_en  = period_end_i &&
                    ((state_q == ST_RAMP) || (state_q == ST_RUN) ||
                     (state_q == ST_STOP_RAMP) || resume);

  pwm_duty_stepper #(.CNT_WIDTH(CNT_WIDTH)) u_stepper (
    .cur      (duty_q),
    .tgt      (ramp_tgt),
    .step     (step_nx),
    .nxt_duty (stepped)
  );

  assign duty_nx = step_en ? stepped : duty_q;

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    udd_d   = udd_q;
    duty_d  = duty_nx;
    case (state_q)
      ST_IDLE: begin
        if (start_i && !stop_i) begin
          state_d = ST_RAMP;
          en_d    = 1'b1;
          udd_d   = 1'b0;
          duty_d  = '0;
        end
      end
      ST_RAMP, ST_RUN: begin
        if (stop_i) state_d = ST_STOP_RAMP;
        else if (step_en) state_d = (duty_nx == ramp_tgt) ? ST_RUN : ST_RAMP;
      end
      ST_STOP_RAMP: begin
        if (resume) state_d = (step_en && duty_nx == tgt_nx) ? ST_RUN : ST_RAMP;
        else if (step_en && duty_nx == '0) state_d = ST_STOP_DRAIN;
      end
      ST_STOP_DRAIN: begin
        if (resume) begin
          state_d = (step_en && duty_nx == tgt_nx) ? ST_RUN : ST_RAMP;
        end else if (period_end_i) begin
          state_d = ST_IDLE;
          en_d    = 1'b0;
          udd_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      en_q        <= 1'b0;
      udd_q       <= 1'b1;
      duty_q      <= '0;
      period_q    <= DFLT_PERIOD;
      tgt_q       <= DFLT_DUTY;
      step_q      <= DFLT_STEP;
      sh_full_q   <= 1'b0;
      sh_period_q <= DFLT_PERIOD;
      sh_duty_q   <= DFLT_DUTY;
      sh_step_q   <= DFLT_STEP;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      udd_q    <= udd_d;
      duty_q   <= duty_d;
      period_q <= period_nx;
      tgt_q    <= tgt_nx;
      step_q   <= step_nx;
      if (apply) begin
        sh_full_q <= 1'b0;
      end else if (cfg_xfer) begin
        sh_full_q   <= 1'b1;
        sh_period_q <= cap_period;
        sh_duty_q   <= cap_duty;
        sh_step_q   <= cfg_step_i;
      end
    end
  end

  assign cfg_ready_o        = !sh_full_q;
  assign pwm_enable_o       = en_q;
  assign period_cycles_o    = period_q;
  assign duty_cycles_o      = duty_q;
  assign use_default_duty_o = udd_q;
  assign state_o            = state_q;
  assign at_target_o        = (state_q == ST_RUN) && (duty_q == tgt_q);
  assign busy_o             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: directed sequences with literal expectations plus
// an arithmetic reference model compared against every output each cycle.
module tb_pwm_ramp_ctrl;

  localparam longint MAXV = 64'h0000_0000_FFFF_FFFF;
  localparam longint DEFP = 20;
  localparam longint DEFD = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, stop_i, cfg_valid_i, period_end_i;
  logic [31:0] cfg_period_i, cfg_duty_i, cfg_step_i;
  logic        cfg_ready_o, pwm_enable_o, use_default_duty_o, at_target_o, busy_o;
  logic [31:0] period_cycles_o, duty_cycles_o;
  logic [2:0]  state_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pwm_ramp_ctrl #(
    .CNT_WIDTH(32), .DEFAULT_PERIOD_CYCLES(20), .DEFAULT_DUTY_CYCLES(7)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_period_i(cfg_period_i), .cfg_duty_i(cfg_duty_i), .cfg_step_i(cfg_step_i),
    .period_end_i(period_end_i), .pwm_enable_o(pwm_enable_o),
    .period_cycles_o(period_cycles_o), .duty_cycles_o(duty_cycles_o),
    .use_default_duty_o(use_default_duty_o), .state_o(state_o),
    .at_target_o(at_target_o), .busy_o(busy_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: modes 0..4 = idle, ramping, running, stopping, draining.
  typedef struct packed {
    logic [2:0] st;
    logic       en;
    logic       udd;
    logic       shf;
    longint     period;
    longint     duty;
    longint     tgt;
    longint     step;
    longint     shp;
    longint     shd;
    longint     shs;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.st = 0; r.en = 0; r.udd = 1; r.shf = 0;
    r.period = DEFP; r.duty = 0; r.tgt = DEFD; r.step = 1;
    r.shp = DEFP; r.shd = DEFD; r.shs = 1;
    return r;
  endfunction

  function automatic longint toward(longint c, longint g, longint s);
    longint r;
    if (s == 0) return g;
    if (c < g) begin
      r = c + s;
      if (r > MAXV) r = MAXV;
      return (r > g) ? g : r;
    end
    if (c > g) begin
      r = c - s;
      if (r < 0) r = 0;
      return (r < g) ? g : r;
    end
    return c;
  endfunction

  function automatic mdl_t mdl_next(mdl_t c, logic start, logic stop, logic cv,
                                    logic [31:0] cp, logic [31:0] cd, logic [31:0] cs,
                                    logic pe);
    mdl_t   n = c;
    logic   resume;
    longint goal;
    longint p = cp;
    longint d = cd;
    longint s = cs;
    if (c.shf && (c.st == 0 || pe)) begin
      n.period = c.shp; n.tgt = c.shd; n.step = c.shs; n.shf = 0;
    end
    if (cv && !c.shf) begin
      n.shf = 1;
      n.shp = (p < 2) ? DEFP : p;
      n.shd = (d > n.shp) ? n.shp : d;
      n.shs = s;
    end
    resume = start && !stop && (c.st == 3 || c.st == 4);
    goal   = (c.st == 3 && !resume) ? 0 : n.tgt;
    if (pe && (c.st == 1 || c.st == 2 || c.st == 3 || resume))
      n.duty = toward(c.duty, goal, n.step);
    case (c.st)
      3'd0: if (start && !stop) begin n.st = 1; n.en = 1; n.udd = 0; n.duty = 0; end
      3'd1, 3'd2: begin
        if (stop) n.st = 3;
        else if (pe) n.st = (n.duty == goal) ? 2 : 1;
      end
      3'd3: begin
        if (resume) n.st = (pe && n.duty == n.tgt) ? 2 : 1;
        else if (pe && n.duty == 0) n.st = 4;
      end
      default: begin
        if (resume) n.st = (pe && n.duty == n.tgt) ? 2 : 1;
        else if (pe) begin n.st = 0; n.en = 0; n.udd = 1; end
      end
    endcase
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= mdl_reset();
    else m <= mdl_next(m, start_i, stop_i, cfg_valid_i, cfg_period_i, cfg_duty_i,
                       cfg_step_i, period_end_i);
  end

  always @(negedge clk) begin
    check("cmp_state", state_o, m.st);
    check("cmp_enable", pwm_enable_o, m.en);
    check("cmp_period", period_cycles_o, m.period);
    check("cmp_duty", duty_cycles_o, m.duty);
    check("cmp_use_dflt", use_default_duty_o, m.udd);
    check("cmp_ready", cfg_ready_o, !m.shf);
    check("cmp_at_target", at_target_o, (m.st == 2) && (m.duty == m.tgt));
    check("cmp_busy", busy_o, m.st != 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pe();
    period_end_i = 1'b1;
    tick();
    period_end_i = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
  endtask

  task automatic send_cfg(input logic [31:0] p, input logic [31:0] d, input logic [31:0] s);
    check("cfg_ready_before", cfg_ready_o, 1);
    cfg_valid_i = 1'b1; cfg_period_i = p; cfg_duty_i = d; cfg_step_i = s;
    tick();
    cfg_valid_i = 1'b0;
    check("cfg_ready_after_capture", cfg_ready_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    start_i = 0; stop_i = 0; cfg_valid_i = 0; period_end_i = 0;
    cfg_period_i = 0; cfg_duty_i = 0; cfg_step_i = 0;
    tick(); tick();
    rst = 1'b0;
    tick();

    check("rst_state", state_o, 0);
    check("rst_enable", pwm_enable_o, 0);
    check("rst_period", period_cycles_o, 20);
    check("rst_duty", duty_cycles_o, 0);
    check("rst_use_dflt", use_default_duty_o, 1);
    check("rst_ready", cfg_ready_o, 1);
    check("rst_at_target", at_target_o, 0);

    // Default target/step after reset: one period_end moves duty by 1.
    pulse_start();
    check("dflt_enable", pwm_enable_o, 1);
    pe();
    check("dflt_step", duty_cycles_o, 1);
    pulse_stop();
    pe();
    check("dflt_stop_duty", duty_cycles_o, 0);
    check("dflt_drain_state", state_o, 4);
    pe();
    check("dflt_idle", state_o, 0);

    // Soft start 0 -> 10 in steps of 3.
    send_cfg(20, 10, 3);
    tick();
    check("t1_ready_idle_apply", cfg_ready_o, 1);
    pulse_start();
    check("t1_enable", pwm_enable_o, 1);
    check("t1_duty0", duty_cycles_o, 0);
    check("t1_use_dflt", use_default_duty_o, 0);
    check("t1_state_ramp", state_o, 1);
    pe(); check("t1_duty_3", duty_cycles_o, 3);
    pe(); check("t1_duty_6", duty_cycles_o, 6);
    pe(); check("t1_duty_9", duty_cycles_o, 9);
    pe(); check("t1_duty_10", duty_cycles_o, 10);
    check("t1_state_run", state_o, 2);
    check("t1_at_target", at_target_o, 1);

    // Config offered on a period_end edge waits for the following period_end.
    cfg_valid_i = 1; cfg_period_i = 40; cfg_duty_i = 4; cfg_step_i = 0; period_end_i = 1;
    tick();
    cfg_valid_i = 0; period_end_i = 0;
    check("t2_period_held", period_cycles_o, 20);
    check("t2_duty_held", duty_cycles_o, 10);
    check("t2_ready_low", cfg_ready_o, 0);
    tick(); tick();
    check("t2_still_held", period_cycles_o, 20);
    pe();
    check("t2_period_40", period_cycles_o, 40);
    check("t2_duty_4", duty_cycles_o, 4);
    check("t2_state_run", state_o, 2);
    check("t2_ready_back", cfg_ready_o, 1);

    // Soft stop from 10 with step 4.
    send_cfg(20, 10, 4);
    pe(); check("t3_duty_8", duty_cycles_o, 8);
    check("t3_period_20", period_cycles_o, 20);
    pe(); check("t3_duty_10", duty_cycles_o, 10);
    pulse_stop();
    check("t3_state_stop", state_o, 3);
    pe(); check("t3_duty_6", duty_cycles_o, 6);
    pe(); check("t3_duty_2", duty_cycles_o, 2);
    pe(); check("t3_duty_0", duty_cycles_o, 0);
    check("t3_drain", state_o, 4);
    check("t3_enable_drain", pwm_enable_o, 1);
    pe();
    check("t3_idle", state_o, 0);
    check("t3_enable_off", pwm_enable_o, 0);
    check("t3_use_dflt", use_default_duty_o, 1);
    check("t3_duty_stays0", duty_cycles_o, 0);

    // Start and stop together in IDLE: stop wins.
    start_i = 1; stop_i = 1;
    tick();
    start_i = 0; stop_i = 0;
    check("t5_both_idle", state_o, 0);
    check("t5_both_enable", pwm_enable_o, 0);

    // Boundaries: short period replaced, target clamped, huge steps saturate.
    send_cfg(1, 50, 32'hFFFF_FFFF);
    tick();
    check("t4_period_dflt", period_cycles_o, 20);
    pulse_start();
    pe();
    check("t4_tgt_clamped", duty_cycles_o, 20);
    check("t4_run", state_o, 2);
    send_cfg(20, 5, 0);
    pe(); check("t4_jump_5", duty_cycles_o, 5);
    send_cfg(100, 60, 32'hFFFF_FFFF);
    pe(); check("t4_up_sat", duty_cycles_o, 60);
    check("t4_period_100", period_cycles_o, 100);
    send_cfg(20, 0, 32'hFFFF_FFFF);
    pe(); check("t4_down_sat", duty_cycles_o, 0);
    check("t4_run_at0", state_o, 2);

    // Restart from a soft stop preserves the current duty.
    send_cfg(20, 10, 4);
    pe(); check("t5_duty_4", duty_cycles_o, 4);
    pe(); check("t5_duty_8", duty_cycles_o, 8);
    pe(); check("t5_duty_10", duty_cycles_o, 10);
    pulse_stop();
    pe(); check("t5_stop_6", duty_cycles_o, 6);
    send_cfg(20, 10, 3);
    pulse_start();
    check("t5_resume_ramp", state_o, 1);
    check("t5_resume_duty", duty_cycles_o, 6);
    pe(); check("t5_resume_9", duty_cycles_o, 9);
    check("t5_still_ramp", state_o, 1);

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t6_enable", pwm_enable_o, 0);
    check("t6_duty", duty_cycles_o, 0);
    check("t6_period", period_cycles_o, 20);
    check("t6_use_dflt", use_default_duty_o, 1);
    check("t6_state", state_o, 0);
    check("t6_ready", cfg_ready_o, 1);
    check("t6_busy", busy_o, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("t6_after_release", state_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
